// File: rtl/define_function_unit.sv
// Purpose : registered f(n) = n * n! / (2n + 1) for a 4-bit operand, 32-bit modular arithmetic.
// Latency : 1 cycle from n to result; one new operand accepted every cycle.
// Backpressure: none; free-running operand bus with no handshake.
//
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   rst_n  - synchronous reset, active-HIGH despite its name
//   n      - unsigned operand 0..15, sampled every rising edge
//   result - registered f(n)
module define_function_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  n,
  output logic [31:0] result
);

  // n! truncated to 32 bits; the multiply wraps naturally for 13..15.
  function automatic logic [31:0] fact32(input logic [3:0] v);
    logic [31:0] acc;
    acc = 32'd1;
    for (int i = 2; i <= 15; i++) begin
      if (i <= int'(v)) begin
        acc = acc * 32'(i);
      end
    end
    return acc;
  endfunction

  // Restoring divider. The partial remainder stays below 2*den <= 62
  // after each shift, so 6 bits are enough.
  function automatic logic [31:0] udiv(input logic [31:0] num, input logic [4:0] den);
    logic [5:0]  rem;
    logic [31:0] quo;
    rem = 6'd0;
    quo = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      rem = {rem[4:0], num[i]};
      if (rem >= {1'b0, den}) begin
        rem    = rem - {1'b0, den};
        quo[i] = 1'b1;
      end
    end
    return quo;
  endfunction

  logic [31:0] fact;
  logic [31:0] prod;
  logic [4:0]  div;
  logic [31:0] result_d;
  logic [31:0] result_q;

  always_comb begin
    fact     = fact32(n);
    prod     = {28'd0, n} * fact;  // low 32 bits kept
    div      = {n, 1'b1};          // 2n + 1, never zero
    result_d = udiv(prod, div);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      result_q <= 32'd0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_define_function_unit.sv
// Purpose : self-checking bench for define_function_unit against an arithmetic reference model.
// Latency : expects result one rising edge after n is applied.
// Backpressure: none; operands are driven every cycle.
module tb_define_function_unit;

  logic        clk;
  logic        rst_n;
  logic [3:0]  n;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  define_function_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .n      (n),
    .result (result)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Reference: straight from the definition using 64-bit integers, masked to 32 bits.
  function automatic logic [31:0] f_model(input int v);
    longint unsigned fct;
    longint unsigned prd;
    fct = 1;
    for (int k = 1; k <= v; k++) begin
      fct = (fct * longint'(k)) & 64'hFFFF_FFFF;
    end
    prd = (longint'(v) * fct) & 64'hFFFF_FFFF;
    return 32'(prd / longint'(2 * v + 1));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply reset/operand, cross one rising edge, then compare away from the edge.
  task automatic step(input logic r, input logic [3:0] v, input string tag, input logic [31:0] exp);
    rst_n = r;
    n     = v;
    @(posedge clk);
    #1;
    check_eq(tag, result, exp);
  endtask

  logic [31:0] sweep_ref [0:8];
  logic [31:0] b2b_ref [0:2];
  logic [3:0]  rv;

  initial begin
    sweep_ref[0] = 32'd0;    sweep_ref[1] = 32'd0;   sweep_ref[2] = 32'd0;
    sweep_ref[3] = 32'd2;    sweep_ref[4] = 32'd10;  sweep_ref[5] = 32'd54;
    sweep_ref[6] = 32'd332;  sweep_ref[7] = 32'd2352; sweep_ref[8] = 32'd18974;
    b2b_ref[0] = 32'd2; b2b_ref[1] = 32'd10; b2b_ref[2] = 32'd54;

    rst_n = 1'b1;
    n     = 4'd5;
    #10;

    // Reset held across several edges with a nonzero operand.
    step(1'b1, 4'd5, "reset_hold0", 32'd0);
    step(1'b1, 4'd5, "reset_hold1", 32'd0);
    step(1'b1, 4'd5, "reset_hold2", 32'd0);
    step(1'b0, 4'd5, "reset_release", 32'd54);

    // Sweep 0..8, two cycles each; reset pulse on the first edge at n=7.
    for (int i = 0; i <= 8; i++) begin
      if (i == 7) begin
        step(1'b1, 4'(i), "midreset_pulse", 32'd0);
        step(1'b0, 4'(i), "midreset_recover", sweep_ref[i]);
      end else begin
        step(1'b0, 4'(i), $sformatf("sweep_n%0d_a", i), sweep_ref[i]);
        step(1'b0, 4'(i), $sformatf("sweep_n%0d_b", i), sweep_ref[i]);
      end
    end

    // Operand change between edges must not disturb the registered output.
    n = 4'd12;
    #20;
    check_eq("hold_between_edges", result, sweep_ref[8]);

    // Wrap boundary.
    step(1'b0, 4'd12, "wrap_n12", 32'd58122076);
    step(1'b0, 4'd13, "wrap_n13", 32'd134883669);
    step(1'b0, 4'd14, "wrap_n14", f_model(14));
    step(1'b0, 4'd15, "wrap_n15", f_model(15));

    // Back-to-back operands, one per cycle.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'(i + 3), $sformatf("b2b_n%0d", i + 3), b2b_ref[i]);
    end

    // Random operands checked against the model.
    for (int i = 0; i < 100; i++) begin
      rv = 4'($urandom_range(0, 15));
      step(1'b0, rv, $sformatf("rand%0d_n%0d", i, rv), f_model(int'(rv)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
